// File: rtl/dffram_2r1w_arb.sv
// Three-client round-robin arbiter in front of a 256x16 DFFRAM with one R/W port and one read-only port.
// Port 0 serves any request; port 1 serves a second reader unless it would read a location being written.
module dffram_2r1w_arb #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16,
    parameter int unsigned NC = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NC-1:0]       REQ,
    input  logic [2*NC-1:0]     WE,
    input  logic [AW*NC-1:0]    ADDR,
    input  logic [DW*NC-1:0]    WDATA,
    output logic [NC-1:0]       GNT,
    output logic [NC-1:0]       RVALID,
    output logic [DW*NC-1:0]    RDATA,
    output logic                EN0,
    output logic [AW-1:0]       A0,
    output logic [DW-1:0]       Di0,
    output logic [1:0]          WE0,
    input  logic [DW-1:0]       Do0,
    output logic                EN1,
    output logic [AW-1:0]       A1,
    input  logic [DW-1:0]       Do1
);

    localparam int unsigned IDW = 2;

    logic [IDW-1:0] rr_q, rr_d;
    logic           r0_vld_q, r0_vld_d, r1_vld_q, r1_vld_d;
    logic [IDW-1:0] r0_id_q, r0_id_d, r1_id_q, r1_id_d;

    logic           p0_vld, p0_we, p1_vld, p1_stop;
    int unsigned    p0_idx, p1_idx, k;
    logic [AW-1:0]  p0_addr;

    // Client occupying priority slot i when the pointer is rr.
    function automatic int unsigned slot(input logic [IDW-1:0] rr, input int unsigned i);
        return (32'(rr) + i) % NC;
    endfunction

    // Port-0 winner, then the first eligible reader for port 1 with the write-hazard stop.
    always_comb begin
        p0_vld  = 1'b0;
        p0_idx  = 0;
        p1_vld  = 1'b0;
        p1_idx  = 0;
        p1_stop = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < NC; i++) begin
            k = slot(rr_q, i);
            if (!RST && !p0_vld && REQ[k]) begin
                p0_vld = 1'b1;
                p0_idx = k;
            end
        end
        p0_we   = p0_vld && (WE[p0_idx*2 +: 2] != 2'b00);
        p0_addr = ADDR[p0_idx*AW +: AW];
        for (int unsigned i = 0; i < NC; i++) begin
            k = slot(rr_q, i);
            if (!RST && !p1_vld && !p1_stop && REQ[k] && !(p0_vld && p0_idx == k)
                && WE[k*2 +: 2] == 2'b00) begin
                if (p0_we && ADDR[k*AW +: AW] == p0_addr) begin
                    p1_stop = 1'b1;
                end else begin
                    p1_vld = 1'b1;
                    p1_idx = k;
                end
            end
        end
    end

    always_comb begin
        rr_d     = p0_vld ? IDW'((p0_idx + 1) % NC) : rr_q;
        r0_vld_d = p0_vld && !p0_we;
        r0_id_d  = IDW'(p0_idx);
        r1_vld_d = p1_vld;
        r1_id_d  = IDW'(p1_idx);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_q     <= '0;
            r0_vld_q <= 1'b0;
            r0_id_q  <= '0;
            r1_vld_q <= 1'b0;
            r1_id_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            r0_vld_q <= r0_vld_d;
            r0_id_q  <= r0_id_d;
            r1_vld_q <= r1_vld_d;
            r1_id_q  <= r1_id_d;
        end
    end

    // RAM port drive and grants.
    always_comb begin
        GNT = '0;
        if (p0_vld) GNT[p0_idx] = 1'b1;
        if (p1_vld) GNT[p1_idx] = 1'b1;
        EN0 = p0_vld;
        A0  = p0_vld ? p0_addr : '0;
        Di0 = p0_vld ? WDATA[p0_idx*DW +: DW] : '0;
        WE0 = p0_vld ? WE[p0_idx*2 +: 2] : 2'b00;
        EN1 = p1_vld;
        A1  = p1_vld ? ADDR[p1_idx*AW +: AW] : '0;
    end

    // Steer returning RAM data to the client recorded in each route register.
    always_comb begin
        RVALID = '0;
        RDATA  = '0;
        for (int unsigned c = 0; c < NC; c++) begin
            if (r0_vld_q && r0_id_q == IDW'(c)) begin
                RVALID[c]          = 1'b1;
                RDATA[c*DW +: DW]  = Do0;
            end else if (r1_vld_q && r1_id_q == IDW'(c)) begin
                RVALID[c]          = 1'b1;
                RDATA[c*DW +: DW]  = Do1;
            end
        end
    end

endmodule

// File: tb/tb_dffram_2r1w_arb.sv
// Directed bench for dffram_2r1w_arb with a behavioural 2-port RAM attached.
module tb_dffram_2r1w_arb;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned NC = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NC-1:0]     REQ;
    logic [2*NC-1:0]   WE;
    logic [AW*NC-1:0]  ADDR;
    logic [DW*NC-1:0]  WDATA;
    logic [NC-1:0]     GNT;
    logic [NC-1:0]     RVALID;
    logic [DW*NC-1:0]  RDATA;
    logic              EN0, EN1;
    logic [AW-1:0]     A0, A1;
    logic [DW-1:0]     Di0, Do0, Do1;
    logic [1:0]        WE0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [256];

    dffram_2r1w_arb #(.AW(AW), .DW(DW), .NC(NC)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
        .EN0(EN0), .A0(A0), .Di0(Di0), .WE0(WE0), .Do0(Do0),
        .EN1(EN1), .A1(A1), .Do1(Do1)
    );

    always #5 CLK = ~CLK;

    // RAM model: synchronous byte-masked write on port 0, registered reads on both ports.
    always @(posedge CLK) begin
        if (EN0) begin
            Do0 <= mem[A0];
            if (WE0[0]) mem[A0][7:0]  <= Di0[7:0];
            if (WE0[1]) mem[A0][15:8] <= Di0[15:8];
        end
        if (EN1) Do1 <= mem[A1];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cl(input int c, input logic r, input logic [1:0] w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        REQ[c]           = r;
        WE[c*2 +: 2]     = w;
        ADDR[c*AW +: AW] = a;
        WDATA[c*DW +: DW] = d;
    endtask

    task automatic clear_all();
        REQ = '0; WE = '0; ADDR = '0; WDATA = '0;
    endtask

    task automatic do_reset();
        clear_all();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_all();
        set_cl(0, 1'b1, 2'b00, 8'd3, 16'd0);
        set_cl(2, 1'b1, 2'b11, 8'd4, 16'd9);
        tick();
        #1;
        checks++; if (GNT !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", GNT, 3'b000); end
        checks++; if (EN0 !== 1'b0 || EN1 !== 1'b0) begin errors++; $display("FAIL reset_en: got %b%b expected 00", EN0, EN1); end
        checks++; if (WE0 !== 2'b00) begin errors++; $display("FAIL reset_we0: got %b expected 00", WE0); end
        tick();
        checks++; if (RVALID !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", RVALID); end
        checks++; if (RDATA !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", RDATA); end
        clear_all();
        RST = 1'b0;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            set_cl(0, 1'b1, 2'b11, 8'(i), 16'(i));
            #1;
            checks++; if (GNT !== 3'b001) begin errors++; $display("FAIL fill_gnt i=%0d: got %b expected 001", i, GNT); end
            checks++; if (EN0 !== 1'b1 || WE0 !== 2'b11 || EN1 !== 1'b0) begin errors++; $display("FAIL fill_ctl i=%0d: got en0=%b we0=%b en1=%b expected 1 11 0", i, EN0, WE0, EN1); end
            checks++; if (A0 !== 8'(i) || Di0 !== 16'(i)) begin errors++; $display("FAIL fill_addr i=%0d: got a0=%0d di0=%0d expected %0d", i, A0, Di0, i); end
            tick();
            checks++; if (RVALID !== 3'b000) begin errors++; $display("FAIL fill_norvalid i=%0d: got %b expected 000", i, RVALID); end
        end
        clear_all();
    endtask

    task automatic test_dual_read();
        do_reset();
        set_cl(1, 1'b1, 2'b00, 8'd5, 16'd0);
        set_cl(2, 1'b1, 2'b00, 8'd250, 16'd0);
        #1;
        checks++; if (GNT !== 3'b110) begin errors++; $display("FAIL dual_gnt: got %b expected 110", GNT); end
        checks++; if (EN0 !== 1'b1 || A0 !== 8'd5 || WE0 !== 2'b00) begin errors++; $display("FAIL dual_p0: got en=%b a=%0d we=%b expected 1 5 00", EN0, A0, WE0); end
        checks++; if (EN1 !== 1'b1 || A1 !== 8'd250) begin errors++; $display("FAIL dual_p1: got en=%b a=%0d expected 1 250", EN1, A1); end
        tick();
        clear_all();
        checks++; if (RVALID !== 3'b110) begin errors++; $display("FAIL dual_rvalid: got %b expected 110", RVALID); end
        checks++; if (RDATA[1*DW +: DW] !== 16'd5) begin errors++; $display("FAIL dual_rdata1: got %h expected 0005", RDATA[1*DW +: DW]); end
        checks++; if (RDATA[2*DW +: DW] !== 16'd250) begin errors++; $display("FAIL dual_rdata2: got %h expected 00fa", RDATA[2*DW +: DW]); end
        checks++; if (RDATA[0 +: DW] !== 16'd0) begin errors++; $display("FAIL dual_rdata0: got %h expected 0000", RDATA[0 +: DW]); end
        tick();
        checks++; if (RVALID !== 3'b000) begin errors++; $display("FAIL dual_pulse: got %b expected 000", RVALID); end
    endtask

    task automatic test_rr_writes();
        logic [NC-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 3; c++) set_cl(c, 1'b1, 2'b11, 8'(100 + c), 16'(100 + c));
        for (int j = 0; j < 6; j++) begin
            exp_g = 3'b001 << (j % 3);
            #1;
            checks++; if (GNT !== exp_g) begin errors++; $display("FAIL rr_gnt j=%0d: got %b expected %b", j, GNT, exp_g); end
            checks++; if (EN1 !== 1'b0) begin errors++; $display("FAIL rr_p1idle j=%0d: got %b expected 0", j, EN1); end
            tick();
        end
        clear_all();
    endtask

    task automatic test_hazard();
        do_reset();
        set_cl(0, 1'b1, 2'b01, 8'd7, 16'hA5A5);
        set_cl(1, 1'b1, 2'b00, 8'd7, 16'd0);
        #1;
        checks++; if (GNT !== 3'b001 || EN1 !== 1'b0) begin errors++; $display("FAIL hz_hold: got gnt=%b en1=%b expected 001 0", GNT, EN1); end
        tick();
        set_cl(0, 1'b0, 2'b00, 8'd0, 16'd0);
        #1;
        checks++; if (GNT !== 3'b010 || A0 !== 8'd7 || WE0 !== 2'b00) begin errors++; $display("FAIL hz_retry: got gnt=%b a0=%0d we0=%b expected 010 7 00", GNT, A0, WE0); end
        tick();
        clear_all();
        checks++; if (RVALID !== 3'b010) begin errors++; $display("FAIL hz_rvalid: got %b expected 010", RVALID); end
        checks++; if (RDATA[1*DW +: DW] !== 16'h00A5) begin errors++; $display("FAIL hz_merge: got %h expected 00a5", RDATA[1*DW +: DW]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cl(0, 1'b1, 2'b00, 8'd5, 16'd0);
        #1;
        checks++; if (GNT !== 3'b001) begin errors++; $display("FAIL rm_gnt: got %b expected 001", GNT); end
        tick();
        clear_all();
        RST = 1'b1;
        set_cl(2, 1'b1, 2'b00, 8'd6, 16'd0);
        #1;
        checks++; if (RVALID !== 3'b001 || RDATA[0 +: DW] !== 16'd5) begin errors++; $display("FAIL rm_rvalid: got %b/%h expected 001/0005", RVALID, RDATA[0 +: DW]); end
        checks++; if (GNT !== 3'b000) begin errors++; $display("FAIL rm_gnt_rst: got %b expected 000", GNT); end
        tick();
        checks++; if (RVALID !== 3'b000 || GNT !== 3'b000) begin errors++; $display("FAIL rm_cleared: got rv=%b gnt=%b expected 000 000", RVALID, GNT); end
        RST = 1'b0;
        clear_all();
        for (int c = 0; c < 3; c++) set_cl(c, 1'b1, 2'b11, 8'(30 + c), 16'(30 + c));
        #1;
        checks++; if (GNT !== 3'b001) begin errors++; $display("FAIL rm_rr0: got %b expected 001", GNT); end
        clear_all();
    endtask

    task automatic test_hazard_chain();
        do_reset();
        set_cl(1, 1'b1, 2'b00, 8'd40, 16'd0);
        tick();
        clear_all();
        set_cl(2, 1'b1, 2'b11, 8'd9, 16'h1234);
        set_cl(0, 1'b1, 2'b00, 8'd9, 16'd0);
        set_cl(1, 1'b1, 2'b00, 8'd10, 16'd0);
        #1;
        checks++; if (GNT !== 3'b100 || EN1 !== 1'b0 || A0 !== 8'd9) begin errors++; $display("FAIL hc_block: got gnt=%b en1=%b a0=%0d expected 100 0 9", GNT, EN1, A0); end
        tick();
        set_cl(2, 1'b0, 2'b00, 8'd0, 16'd0);
        #1;
        checks++; if (GNT !== 3'b011 || A0 !== 8'd9 || A1 !== 8'd10 || EN1 !== 1'b1) begin errors++; $display("FAIL hc_retry: got gnt=%b a0=%0d a1=%0d en1=%b expected 011 9 10 1", GNT, A0, A1, EN1); end
        tick();
        clear_all();
        checks++; if (RVALID !== 3'b011) begin errors++; $display("FAIL hc_rvalid: got %b expected 011", RVALID); end
        checks++; if (RDATA[0 +: DW] !== 16'h1234 || RDATA[1*DW +: DW] !== 16'd10) begin errors++; $display("FAIL hc_rdata: got %h/%h expected 1234/000a", RDATA[0 +: DW], RDATA[1*DW +: DW]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_cl(2, 1'b1, 2'b00, 8'd50, 16'd0);
        #1;
        checks++; if (GNT !== 3'b100) begin errors++; $display("FAIL b2b_gnt0: got %b expected 100", GNT); end
        tick();
        set_cl(2, 1'b1, 2'b00, 8'd51, 16'd0);
        #1;
        checks++; if (RVALID !== 3'b100 || RDATA[2*DW +: DW] !== 16'd50) begin errors++; $display("FAIL b2b_first: got %b/%h expected 100/0032", RVALID, RDATA[2*DW +: DW]); end
        checks++; if (GNT !== 3'b100) begin errors++; $display("FAIL b2b_gnt1: got %b expected 100", GNT); end
        tick();
        clear_all();
        checks++; if (RVALID !== 3'b100 || RDATA[2*DW +: DW] !== 16'd51) begin errors++; $display("FAIL b2b_second: got %b/%h expected 100/0033", RVALID, RDATA[2*DW +: DW]); end
        tick();
        checks++; if (RVALID !== 3'b000 || RDATA !== '0) begin errors++; $display("FAIL b2b_end: got %b/%h expected 000/0", RVALID, RDATA); end
    endtask

    initial begin
        RST = 1'b1;
        clear_all();
        tick();
        test_reset();
        test_fill();
        test_dual_read();
        test_rr_writes();
        test_hazard();
        test_reset_mid();
        test_hazard_chain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
